sc_comp: RTL and testbench
==========================

# sc_comp

Single-cycle 32-bit RISC-V (RV32I subset) computer: CPU core, instruction ROM and data RAM in one block. Every instruction completes in one clock. The top-level integration unit drives it for simulation and board demos. A debug port exposes any architectural register combinationally. Programs such as the student sort are loaded into the ROM.

## Interface
- Parameters: none. IM depth is fixed at 128 words and DM depth at 128 words.
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  reset; asynchronous, active-high (1 = reset), despite the name.
- reg_sel  input  5  debug register index 0–31.
- reg_data  output  32  contents of register x[reg_sel], combinational. x0 reads 0.

## Operation
- Hierarchy:
  - instruction memory instance U_IM, holding array ROM[0:127] of 32-bit words.
  - ROM is loaded externally by $readmemh.
  - ROM is read asynchronously at index PC[8:2].
- PC: 32-bit. Next PC is one of:
  - PC+4 (default);
  - PC+imm for a taken branch or jal;
  - (rs1+imm) & ~1 for jalr.
- Register file:
  - 32×32 bits, two asynchronous read ports plus the debug read port.
  - One write port, written on the rising clk edge when RegWrite=1 and rd≠0.
  - x0 is hardwired to 0.
- Data memory:
  - 128×32 bits, word-addressed by ALUout[8:2].
  - Asynchronous read; synchronous write on sw.
  - Not cleared by reset.
- Supported instructions (any other opcode executes as a NOP: PC+4, no writes):
  - R-type: add, sub, and, or, xor, sll, srl, sra, slt, sltu.
  - I-type ALU: addi, andi, ori, xori, slti, sltiu, slli, srli, srai. Shift amount is instr[24:20].
  - Memory: lw, sw (word only).
  - Branches: beq, bne, blt, bge (signed), bltu, bgeu.
  - Upper immediate: lui, auipc.
  - Jumps: jal, jalr. Both write rd = PC+4.
- Immediates are sign-extended from instr[31] in the standard I, S, B, U and J formats. B and J immediates have bit 0 = 0.
- ALU arithmetic:
  - 32-bit wraparound; no overflow trap.
  - slt is signed; sltu is unsigned.
  - Shifts use the low 5 bits of the operand.
- Writeback select: ALU result, DM read data, PC+4, or U-immediate for lui.
- Misaligned addresses are not checked:
  - the low two address bits are ignored for DM;
  - an unaligned target PC fetches word PC[8:2].

## Timing
- Reset asserted (asynchronous): PC=0 and all 32 registers = 0 immediately. reg_data = 0 for every reg_sel.
- Reset deasserted: the first rising edge executes ROM[0].
- Each rising clk edge (reset low) commits exactly one instruction:
  - PC, the rd write and any DM write update together.
  - The next instruction sees the new values.
- Reset asserted mid-program: PC and registers clear at once; DM contents are retained.
- reg_data:
  - follows reg_sel combinationally within the same cycle;
  - reflects a register write right after the edge that commits it.
- Store then load to the same address in the next cycle returns the stored value.
- A branch or jump targets the next edge; there are no delay slots and no stalls.

## Test plan
- Reset: hold rstn=1 for 20 ns → PC=0; reg_data=0 for reg_sel 0..31. Release → ROM[0] executes on the first edge.
- ALU: addi x5,x0,5; addi x6,x0,-3; add x7,x5,x6; sub x8,x6,x5; sra x9,x6,x5 (sra uses shift amount from x5 = 5) → reg_sel=7 gives 2; reg_sel=8 gives 0xFFFFFFF8; reg_sel=9 gives 0xFFFFFFFF. slt x10,x6,x5 → 1; sltu x10,x6,x5 → 0.
- Memory: addi x1,x0,0x55; sw x1,8(x0); lw x2,8(x0) → x2=0x55. addi x0,x0,1 → reg_sel=0 still reads 0.
- Control flow:
  - beq x1,x1,+8 skips the next addi;
  - bne with equal operands falls through;
  - jal x1,+12 → x1 = old PC+4, PC = old PC+12;
  - jalr x0,0(x1) returns.
- Program: student sort.
  - Load the sort program into ROM with 8 unsorted words stored into DM.
  - Run 1000 ns+ at 100 ns clock period.
  - DM words read back in ascending signed order.
  - reg_sel=7 matches the program's final x7 value.
- Mid-run reset: assert rstn during execution → PC and registers return to 0 asynchronously. After release, execution restarts from ROM[0].

Source files
------------

// File: rtl/sc_comp.sv
// sc_comp: single-cycle RV32I-subset computer (core + 128-word instruction ROM
// + 128-word data RAM). One instruction commits on every rising clk edge.
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   rstn      asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   reg_sel   debug register index 0..31
//   reg_data  combinational contents of x[reg_sel] (x0 reads 0)
//
// Reset clears PC and the register file only; data RAM keeps its contents.
// The ROM (U_IM.ROM) has no write port: its image is placed there from
// outside the design (hierarchical preload).

// Instruction ROM, asynchronous read by word index.
module sc_im (
    input  logic [6:0]  addr,
    output logic [31:0] data
);
    logic [31:0] ROM [0:127];

    assign data = ROM[addr];
endmodule

module sc_comp (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;

    // funct3 -> ALU op; bit 30 selects sub (R-type only) and sra/srai
    function automatic alu_op_t decode_alu(input logic [2:0] f3,
                                           input logic       alt,
                                           input logic       is_r);
        case (f3)
            3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0] pc, pc_plus4, pc_target, pc_next;
    logic [31:0] instr;

    sc_im U_IM (
        .addr (pc[8:2]),
        .data (instr)
    );

    // instruction fields
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic       alt;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign alt    = instr[30];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // register file; x0 is reset to 0 and never written, so it always reads 0
    logic [31:0] rf [0:31];
    logic [31:0] rs1_val, rs2_val;

    assign rs1_val  = rf[rs1];
    assign rs2_val  = rf[rs2];
    assign reg_data = rf[reg_sel];

    // decode
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    logic [31:0] imm;
    logic        alu_a_pc, alu_b_imm;
    logic        reg_write, mem_write;
    logic        is_branch, is_jal, is_jalr;

    always_comb begin
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        imm       = imm_i;
        alu_a_pc  = 1'b0;
        alu_b_imm = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = decode_alu(funct3, alt, 1'b1);
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_b_imm = 1'b1;
                alu_op    = decode_alu(funct3, alt, 1'b0);
            end
            OP_LOAD: begin
                // only lw is supported; other widths fall through as NOP
                if (funct3 == 3'b010) begin
                    reg_write = 1'b1;
                    alu_b_imm = 1'b1;
                    wb_sel    = WB_MEM;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    mem_write = 1'b1;
                    alu_b_imm = 1'b1;
                    imm       = imm_s;
                end
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                imm       = imm_b;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                wb_sel    = WB_IMM;
                imm       = imm_u;
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                alu_a_pc  = 1'b1;
                alu_b_imm = 1'b1;
                imm       = imm_u;
            end
            OP_JAL: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC4;
                is_jal    = 1'b1;
                imm       = imm_j;
            end
            OP_JALR: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC4;
                alu_b_imm = 1'b1;
                is_jalr   = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU
    logic [31:0] alu_a, alu_b, alu_y;

    assign alu_a = alu_a_pc  ? pc  : rs1_val;
    assign alu_b = alu_b_imm ? imm : rs2_val;

    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_SLL:  alu_y = alu_a << alu_b[4:0];
            ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_y = $signed(alu_a) >>> alu_b[4:0];
            ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
            default:  alu_y = 32'd0;
        endcase
    end

    // branch condition (funct3 010/011 are not branches and never take)
    logic br_cond;

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000: br_cond = (rs1_val == rs2_val);
            3'b001: br_cond = (rs1_val != rs2_val);
            3'b100: br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101: br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: br_cond = (rs1_val <  rs2_val);
            3'b111: br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_plus4  = pc + 32'd4;
    assign pc_target = pc + imm;

    always_comb begin
        pc_next = pc_plus4;
        if (is_jalr)
            pc_next = alu_y & ~32'd1;
        else if (is_jal || (is_branch && br_cond))
            pc_next = pc_target;
    end

    // data RAM: word address ignores the low two bits; no reset
    logic [31:0] dm [0:127];
    logic [31:0] dm_rdata;

    assign dm_rdata = dm[alu_y[8:2]];

    always_ff @(posedge clk) begin
        if (mem_write && !rstn)
            dm[alu_y[8:2]] <= rs2_val;
    end

    // writeback
    logic [31:0] wb_data;

    always_comb begin
        wb_data = alu_y;
        case (wb_sel)
            WB_ALU: wb_data = alu_y;
            WB_MEM: wb_data = dm_rdata;
            WB_PC4: wb_data = pc_plus4;
            WB_IMM: wb_data = imm_u;
            default: wb_data = alu_y;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else begin
            pc <= pc_next;
            if (reg_write && rd != 5'd0)
                rf[rd] <= wb_data;
        end
    end
endmodule

// File: tb/tb_sc_comp.sv
// Directed bench for sc_comp: reset, ALU/memory/control-flow program stepped
// one instruction at a time, bubble-sort program, and mid-run reset.
module tb_sc_comp;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic        clk;
    logic        rstn;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    sc_comp dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;   // 100 ns period

    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] e_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] e_s(input logic [11:0] im, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] e_b(input logic [12:0] im, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] e_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] e_u(input logic [19:0] im, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {im, rd, op};
    endfunction

    task automatic put(input int a, input logic [31:0] w);
        dut.U_IM.ROM[a] = w;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = 32'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] sel, input logic [31:0] exp);
        reg_sel = sel;
        #1;
        chk(tag, reg_data, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sort_in  [8];
    logic [31:0] sort_exp [8];

    initial begin
        sort_in  = '{32'd5, 32'hFFFFFFFE, 32'd100, 32'd0, 32'hFFFFFFF9, 32'd33, 32'd1, 32'hFFFFFF9C};
        sort_exp = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd0, 32'd1, 32'd5, 32'd33, 32'd100};

        // ---------------- reset ----------------
        rstn    = 1'b1;
        reg_sel = 5'd0;
        #10;
        chk("reset_pc", dut.pc, 32'd0);
        for (int i = 0; i < 32; i++) begin
            reg_sel = 5'(i);
            #0.1;
            chk($sformatf("reset_x%0d", i), reg_data, 32'd0);
        end

        // ---------------- program 1: ALU / memory / control ----------------
        clear_rom();
        put(0,  e_i(12'd5,   5'd0, 3'b000, 5'd5, OP_I));           // addi x5,x0,5
        put(1,  e_i(12'hFFD, 5'd0, 3'b000, 5'd6, OP_I));           // addi x6,x0,-3
        put(2,  e_r(7'h00, 5'd6, 5'd5, 3'b000, 5'd7));             // add x7,x5,x6
        put(3,  e_r(7'h20, 5'd5, 5'd6, 3'b000, 5'd8));             // sub x8,x6,x5
        put(4,  e_r(7'h20, 5'd5, 5'd6, 3'b101, 5'd9));             // sra x9,x6,x5
        put(5,  e_r(7'h00, 5'd5, 5'd6, 3'b010, 5'd10));            // slt x10,x6,x5
        put(6,  e_r(7'h00, 5'd5, 5'd6, 3'b011, 5'd10));            // sltu x10,x6,x5
        put(7,  e_i(12'h055, 5'd0, 3'b000, 5'd1, OP_I));           // addi x1,x0,0x55
        put(8,  e_s(12'd8, 5'd1, 5'd0));                           // sw x1,8(x0)
        put(9,  e_i(12'd8, 5'd0, 3'b010, 5'd2, OP_LD));            // lw x2,8(x0)
        put(10, e_i(12'd1, 5'd0, 3'b000, 5'd0, OP_I));             // addi x0,x0,1
        put(11, e_b(13'd8, 5'd1, 5'd1, 3'b000));                   // beq x1,x1,+8
        put(12, e_i(12'd1, 5'd0, 3'b000, 5'd12, OP_I));            // addi x12 (skipped)
        put(13, e_b(13'd8, 5'd1, 5'd1, 3'b001));                   // bne x1,x1,+8
        put(14, e_i(12'd7, 5'd0, 3'b000, 5'd13, OP_I));            // addi x13,x0,7
        put(15, e_j(21'd12, 5'd1));                                // jal x1,+12
        put(16, e_i({7'd0, 5'd28}, 5'd6, 3'b101, 5'd15, OP_I));    // srli x15,x6,28
        put(17, e_j(21'd0, 5'd0));                                 // jal x0,0 (halt)
        put(18, e_u(20'h12345, 5'd16, OP_LUI));                    // lui x16
        put(19, e_u(20'h00001, 5'd17, OP_AUI));                    // auipc x17
        put(20, e_i(12'd0, 5'd1, 3'b000, 5'd0, OP_JALR));          // jalr x0,0(x1)
        #10;
        rstn = 1'b0;   // released at t=20, first edge at t=50

        step(); chk("p1_pc0", dut.pc, 32'd4);  chk_reg("addi_x5", 5'd5, 32'd5);
        step(); chk_reg("addi_neg_x6", 5'd6, 32'hFFFFFFFD);
        step(); chk_reg("add_x7", 5'd7, 32'd2);
        step(); chk_reg("sub_x8", 5'd8, 32'hFFFFFFF8);
        step(); chk_reg("sra_x9", 5'd9, 32'hFFFFFFFF);
        step(); chk_reg("slt_x10", 5'd10, 32'd1);
        step(); chk_reg("sltu_x10", 5'd10, 32'd0);
        step(); chk_reg("addi_x1", 5'd1, 32'h55);
        step(); chk("sw_dm2", dut.dm[2], 32'h55);
        step(); chk_reg("lw_x2", 5'd2, 32'h55);
        step(); chk_reg("x0_hardwired", 5'd0, 32'd0);  chk("pc_after_x0", dut.pc, 32'd44);
        step(); chk("beq_taken_pc", dut.pc, 32'd52);
        step(); chk("bne_fall_pc", dut.pc, 32'd56);
        step(); chk_reg("addi_x13", 5'd13, 32'd7);     chk_reg("skipped_x12", 5'd12, 32'd0);
        step(); chk("jal_pc", dut.pc, 32'd72);         chk_reg("jal_link_x1", 5'd1, 32'd64);
        step(); chk_reg("lui_x16", 5'd16, 32'h12345000);
        step(); chk_reg("auipc_x17", 5'd17, 32'h0000104C);
        step(); chk("jalr_pc", dut.pc, 32'd64);
        step(); chk_reg("srli_x15", 5'd15, 32'h0000000F);
        step(); chk("halt_pc", dut.pc, 32'd68);
        step(); chk("halt_pc_hold", dut.pc, 32'd68);

        // ---------------- program 2: bubble sort ----------------
        #10;
        rstn = 1'b1;
        #10;
        clear_rom();
        for (int k = 0; k < 8; k++) begin
            put(2 * k,     e_i(sort_in[k][11:0], 5'd0, 3'b000, 5'd1, OP_I)); // addi x1,x0,v
            put(2 * k + 1, e_s(12'(k * 4), 5'd1, 5'd0));                    // sw x1,4k(x0)
        end
        put(16, e_i(12'd0,  5'd0, 3'b000, 5'd7, OP_I));    // x7 = pass count
        put(17, e_i(12'd7,  5'd0, 3'b000, 5'd8, OP_I));    // x8 = 7 passes
        put(18, e_b(13'd52, 5'd8, 5'd7, 3'b000));          // beq x7,x8,DONE
        put(19, e_i(12'd0,  5'd0, 3'b000, 5'd3, OP_I));    // x3 = ptr
        put(20, e_i(12'd28, 5'd0, 3'b000, 5'd4, OP_I));    // x4 = end ptr
        put(21, e_b(13'd32, 5'd4, 5'd3, 3'b000));          // beq x3,x4,NEXT
        put(22, e_i(12'd0,  5'd3, 3'b010, 5'd5, OP_LD));   // lw x5,0(x3)
        put(23, e_i(12'd4,  5'd3, 3'b010, 5'd6, OP_LD));   // lw x6,4(x3)
        put(24, e_b(13'd12, 5'd5, 5'd6, 3'b101));          // bge x6,x5,NOSWAP
        put(25, e_s(12'd0,  5'd6, 5'd3));                  // sw x6,0(x3)
        put(26, e_s(12'd4,  5'd5, 5'd3));                  // sw x5,4(x3)
        put(27, e_i(12'd4,  5'd3, 3'b000, 5'd3, OP_I));    // addi x3,x3,4
        put(28, e_j(21'h1FFFE4, 5'd0));                    // jal x0,-28
        put(29, e_i(12'd1,  5'd7, 3'b000, 5'd7, OP_I));    // addi x7,x7,1
        put(30, e_j(21'h1FFFD0, 5'd0));                    // jal x0,-48
        put(31, e_j(21'd0, 5'd0));                         // DONE: jal x0,0
        @(negedge clk);
        rstn = 1'b0;

        step(); chk("sort_first_pc", dut.pc, 32'd4);  chk_reg("sort_first_x1", 5'd1, 32'd5);
        repeat (1000) @(posedge clk);
        #1;
        chk("sort_done_pc", dut.pc, 32'd124);
        chk_reg("sort_x7", 5'd7, 32'd7);
        for (int k = 0; k < 8; k++)
            chk($sformatf("sort_dm%0d", k), dut.dm[k], sort_exp[k]);

        // ---------------- mid-run reset ----------------
        #20;
        rstn = 1'b1;   // asserted between edges
        #1;
        chk("midrst_pc", dut.pc, 32'd0);
        chk_reg("midrst_x7", 5'd7, 32'd0);
        chk_reg("midrst_x8", 5'd8, 32'd0);
        chk("midrst_dm0_kept", dut.dm[0], 32'hFFFFFF9C);
        chk("midrst_dm7_kept", dut.dm[7], 32'd100);
        @(negedge clk);
        rstn = 1'b0;
        step(); chk("restart_pc", dut.pc, 32'd4);   chk_reg("restart_x1", 5'd1, 32'd5);
        step(); chk("restart_dm0", dut.dm[0], 32'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
